int_issue_queue: RTL

- Reservation station sitting directly upstream of the integer ALU.
- Buffers renamed integer uops until their source operands are available, capturing operand data from result-bus broadcasts.
- Issues the oldest ready uop each cycle into a registered output stage that feeds the ALU.
- Drops squashed uops when the ALU resolves a taken branch.

---
 rtl/int_issue_queue_pkg.sv | 34 +++
 rtl/iq_wakeup.sv | 27 ++
 rtl/int_issue_queue.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/int_issue_queue_pkg.sv
// Shared types and constants for the integer issue queue.
package int_issue_queue_pkg;

    localparam int unsigned TAG_W  = 6;
    localparam int unsigned SQN_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NM_W   = 5;

    typedef enum logic [3:0] {
        INT_ADD  = 4'd0,  INT_SUB  = 4'd1,  INT_AND  = 4'd2,  INT_OR   = 4'd3,
        INT_XOR  = 4'd4,  INT_SLL  = 4'd5,  INT_SRL  = 4'd6,  INT_SRA  = 4'd7,
        INT_SLT  = 4'd8,  INT_SLTU = 4'd9,  INT_LUI  = 4'd10, INT_AUIPC = 4'd11,
        INT_JAL  = 4'd12, INT_BEQ  = 4'd13, INT_BNE  = 4'd14, INT_BLT  = 4'd15
    } OPCode_INT;

    typedef struct packed {
        logic                        valid;
        OPCode_INT                   opcode;
        logic [2:0][DATA_W-1:0]      operands;
        logic [1:0]                  opReady;
        logic [1:0][TAG_W-1:0]       opTag;
        logic [TAG_W-1:0]            tagDst;
        logic [NM_W-1:0]             nmDst;
        logic [SQN_W-1:0]            sqN;
    } IQEntry_INT;

    // True when sqn is strictly younger than br under 6-bit wrap arithmetic.
    function automatic logic is_younger(input logic [SQN_W-1:0] sqn, input logic [SQN_W-1:0] br);
        logic [SQN_W-1:0] diff;
        diff = sqn - br;
        return (diff != '0) && !diff[SQN_W-1];
    endfunction

endpackage

// File: rtl/iq_wakeup.sv
// Single-operand tag comparator across all result-bus broadcast ports.
module iq_wakeup
    import int_issue_queue_pkg::*;
#(
    parameter int unsigned NUM_WB = 2
) (
    input  logic [TAG_W-1:0]               tag_i,
    input  logic [NUM_WB-1:0]              res_valid_i,
    input  logic [NUM_WB-1:0][TAG_W-1:0]   res_tag_i,
    input  logic [NUM_WB-1:0][DATA_W-1:0]  res_data_i,
    output logic                           match_c_o,
    output logic [DATA_W-1:0]              data_c_o
);

    // Lowest matching port wins.
    always_comb begin
        match_c_o = 1'b0;
        data_c_o  = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (!match_c_o && res_valid_i[p] && (res_tag_i[p] == tag_i)) begin
                match_c_o = 1'b1;
                data_c_o  = res_data_i[p];
            end
        end
    end

endmodule

// File: rtl/int_issue_queue.sv
// Integer reservation station: age-ordered compacting queue with operand capture,
// oldest-ready select into a registered ALU issue stage, and branch flush.
module int_issue_queue
    import int_issue_queue_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned NUM_WB      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           IN_valid,
    input  OPCode_INT                      IN_opcode,
    input  logic [2:0][DATA_W-1:0]         IN_operands,
    input  logic [1:0]                     IN_opReady,
    input  logic [1:0][TAG_W-1:0]          IN_opTag,
    input  logic [TAG_W-1:0]               IN_tagDst,
    input  logic [NM_W-1:0]                IN_nmDst,
    input  logic [SQN_W-1:0]               IN_sqN,
    output logic                           OUT_full,
    input  logic [NUM_WB-1:0]              IN_resValid,
    input  logic [NUM_WB-1:0][TAG_W-1:0]   IN_resTag,
    input  logic [NUM_WB-1:0][DATA_W-1:0]  IN_resData,
    input  logic                           IN_wbStall,
    input  logic                           IN_branchTaken,
    input  logic [SQN_W-1:0]               IN_branchSqN,
    output logic                           OUT_valid,
    output OPCode_INT                      OUT_opcode,
    output logic [2:0][DATA_W-1:0]         OUT_operands,
    output logic [TAG_W-1:0]               OUT_tagDst,
    output logic [NM_W-1:0]                OUT_nmDst,
    output logic [SQN_W-1:0]               OUT_sqN
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

    IQEntry_INT [NUM_ENTRIES-1:0] entries_q, entries_d;
    logic                         full_q, full_d;
    logic                         out_valid_q, out_valid_d;
    OPCode_INT                    out_opcode_q, out_opcode_d;
    logic [2:0][DATA_W-1:0]       out_operands_q, out_operands_d;
    logic [TAG_W-1:0]             out_tag_dst_q, out_tag_dst_d;
    logic [NM_W-1:0]              out_nm_dst_q, out_nm_dst_d;
    logic [SQN_W-1:0]             out_sqn_q, out_sqn_d;

    logic [NUM_ENTRIES:0][1:0][TAG_W-1:0]  wk_tag;
    logic [NUM_ENTRIES:0][1:0]             wk_hit;
    logic [NUM_ENTRIES:0][1:0][DATA_W-1:0] wk_data;

    logic [NUM_ENTRIES-1:0] squash;
    logic                   in_squash, out_squash;
    logic                   sel_found, out_fire, issue;
    logic [IDX_W-1:0]       sel_idx;
    logic [CNT_W-1:0]       fill;
    IQEntry_INT             ent_tmp;

    // Slot NUM_ENTRIES of the comparator array serves the enqueue port.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            wk_tag[i] = entries_q[i].opTag;
        end
        wk_tag[NUM_ENTRIES] = IN_opTag;
    end

    for (genvar g = 0; g <= NUM_ENTRIES; g++) begin : g_wk_ent
        for (genvar o = 0; o < 2; o++) begin : g_wk_op
            iq_wakeup #(.NUM_WB(NUM_WB)) u_wakeup (
                .tag_i       (wk_tag[g][o]),
                .res_valid_i (IN_resValid),
                .res_tag_i   (IN_resTag),
                .res_data_i  (IN_resData),
                .match_c_o   (wk_hit[g][o]),
                .data_c_o    (wk_data[g][o])
            );
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            squash[i] = IN_branchTaken && is_younger(entries_q[i].sqN, IN_branchSqN);
        end
        in_squash  = IN_branchTaken && is_younger(IN_sqN, IN_branchSqN);
        out_squash = IN_branchTaken && is_younger(out_sqn_q, IN_branchSqN);
    end

    // Oldest ready, non-squashed entry from registered state.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!sel_found && entries_q[i].valid && (&entries_q[i].opReady) && !squash[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        out_fire = !IN_wbStall || !out_valid_q;
        issue    = out_fire && sel_found;
    end

    always_comb begin
        out_valid_d    = out_valid_q && !out_squash;
        out_opcode_d   = out_opcode_q;
        out_operands_d = out_operands_q;
        out_tag_dst_d  = out_tag_dst_q;
        out_nm_dst_d   = out_nm_dst_q;
        out_sqn_d      = out_sqn_q;
        if (out_fire) begin
            out_valid_d = sel_found;
            if (sel_found) begin
                out_opcode_d   = entries_q[sel_idx].opcode;
                out_operands_d = entries_q[sel_idx].operands;
                out_tag_dst_d  = entries_q[sel_idx].tagDst;
                out_nm_dst_d   = entries_q[sel_idx].nmDst;
                out_sqn_d      = entries_q[sel_idx].sqN;
            end
        end
    end

    // Compact survivors with captured operands, then append the enqueued uop.
    always_comb begin
        entries_d = '0;
        fill      = '0;
        ent_tmp   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_tmp = entries_q[i];
            for (int o = 0; o < 2; o++) begin
                if (!ent_tmp.opReady[o] && wk_hit[i][o]) begin
                    ent_tmp.opReady[o]  = 1'b1;
                    ent_tmp.operands[o] = wk_data[i][o];
                end
            end
            if (entries_q[i].valid && !squash[i] && !(issue && (sel_idx == IDX_W'(i)))) begin
                entries_d[IDX_W'(fill)] = ent_tmp;
                fill = fill + CNT_W'(1);
            end
        end
        if (IN_valid && !full_q && !in_squash) begin
            ent_tmp.valid    = 1'b1;
            ent_tmp.opcode   = IN_opcode;
            ent_tmp.operands = IN_operands;
            ent_tmp.opReady  = IN_opReady;
            ent_tmp.opTag    = IN_opTag;
            ent_tmp.tagDst   = IN_tagDst;
            ent_tmp.nmDst    = IN_nmDst;
            ent_tmp.sqN      = IN_sqN;
            for (int o = 0; o < 2; o++) begin
                if (!IN_opReady[o] && wk_hit[NUM_ENTRIES][o]) begin
                    ent_tmp.opReady[o]  = 1'b1;
                    ent_tmp.operands[o] = wk_data[NUM_ENTRIES][o];
                end
            end
            entries_d[IDX_W'(fill)] = ent_tmp;
            fill = fill + CNT_W'(1);
        end
        full_d = (fill == CNT_W'(NUM_ENTRIES));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q      <= '0;
            full_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_opcode_q   <= INT_ADD;
            out_operands_q <= '0;
            out_tag_dst_q  <= '0;
            out_nm_dst_q   <= '0;
            out_sqn_q      <= '0;
        end else begin
            entries_q      <= entries_d;
            full_q         <= full_d;
            out_valid_q    <= out_valid_d;
            out_opcode_q   <= out_opcode_d;
            out_operands_q <= out_operands_d;
            out_tag_dst_q  <= out_tag_dst_d;
            out_nm_dst_q   <= out_nm_dst_d;
            out_sqn_q      <= out_sqn_d;
        end
    end

    assign OUT_full     = full_q;
    assign OUT_valid    = out_valid_q;
    assign OUT_opcode   = out_opcode_q;
    assign OUT_operands = out_operands_q;
    assign OUT_tagDst   = out_tag_dst_q;
    assign OUT_nmDst    = out_nm_dst_q;
    assign OUT_sqN      = out_sqn_q;

endmodule
